// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
//   state_e      : clear-sequencer states (ST_INIT while zeroing, ST_RUN afterwards)
//   *_DEF        : default data/address widths used by regfile_mp
//   even_parity  : even-parity bit of a (zero-extended) data word
package regfile_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned PAR_MAX_W  = 64;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Zero-extension does not change the XOR reduction, so one width serves all DATA_W <= 64.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage : regfile_pkg

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard for RAW hazard detection.
//   clk_i, rst_i : clock, asynchronous active-low reset (clears every busy bit)
//   wr_en_i      : producer wrote back wr_addr_i -> clear its busy bit
//   rsv_en_i     : producer issued for rsv_addr_i -> set its busy bit (set beats clear)
//   rd_addr_i    : packed read addresses, port k = [k*ADDR_W +: ADDR_W]
//   busy_o       : raw busy bit per read port (bypass masking is done by the caller)
module regfile_scoreboard #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_en_i,
    input  logic [ADDR_W-1:0]        wr_addr_i,
    input  logic                     rsv_en_i,
    input  logic [ADDR_W-1:0]        rsv_addr_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD-1:0]        busy_o
);

    localparam int unsigned DEPTH   = 1 << ADDR_W;
    localparam logic        ZERO_EN = (ZERO_REG != 32'd0);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Clear first, then set, so a same-cycle reservation of the written register wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_en_i) begin
            busy_d[wr_addr_i] = 1'b0;
        end
        if (rsv_en_i) begin
            busy_d[rsv_addr_i] = 1'b1;
        end
        if (ZERO_EN) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Busy read mux, one per read port.
    always_comb begin
        busy_o = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            busy_o[k] = busy_q[rd_addr_i[k*ADDR_W +: ADDR_W]];
        end
    end

endmodule : regfile_scoreboard

// File: rtl/regfile_mp.sv
// Multi-read-port register file with a hardware clear sequencer and busy scoreboard.
// Optional build macro: REGFILE_PARITY_EN adds one stored even-parity bit per entry;
// without it par_err_o is tied to 0 (port list identical in both builds).
//   clk_i, rst_i : clock, asynchronous active-low reset (restarts the clear sequence)
//   init_done_o  : registered, 1 once every entry has been zeroed
//   rd_addr_i    : packed read addresses, port k = [k*ADDR_W +: ADDR_W]
//   rd_data_o    : combinational read data with write-through bypass
//   busy_o       : combinational busy per read port (all 1 while clearing)
//   par_err_o    : combinational parity error per read port
//   wr_en_i, wr_addr_i, wr_data_i : write-back port
//   rsv_en_i, rsv_addr_i          : issue-time reservation port
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    output logic                     init_done_o,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        busy_o,
    output logic [NUM_RD-1:0]        par_err_o,
    input  logic                     wr_en_i,
    input  logic [ADDR_W-1:0]        wr_addr_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic                     rsv_en_i,
    input  logic [ADDR_W-1:0]        rsv_addr_i
);

    localparam int unsigned DEPTH   = 1 << ADDR_W;
    localparam int unsigned CNT_W   = ADDR_W + 1;
    localparam logic        ZERO_EN = (ZERO_REG != 32'd0);

    // ------------------------------------------------------------------
    // Clear sequencer state
    // ------------------------------------------------------------------
    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             init_done_q;
    logic             init_done_d;

    logic             run;
    logic             wr_ok;

    assign run   = (state_q == ST_RUN);
    // Accepted write: only after clearing, and never to the hard-wired zero entry.
    assign wr_ok = run && wr_en_i && !(ZERO_EN && (wr_addr_i == '0));

    // Next-state logic; cnt is one bit wider than the address so it never wraps.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DEPTH - 1)) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                init_done_d = 1'b1;
            end
            default: begin
                state_d     = ST_INIT;
                cnt_d       = '0;
                init_done_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
        end
    end

    assign init_done_o = init_done_q;

    // ------------------------------------------------------------------
    // Storage write port: the sequencer owns it while clearing
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (!run) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q[ADDR_W-1:0];
        end else if (wr_ok) begin
            mem_we    = 1'b1;
            mem_waddr = wr_addr_i;
            mem_wdata = wr_data_i;
        end
    end

    // Storage array carries no reset; the clear sequence zeroes it.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

`ifdef REGFILE_PARITY_EN
    logic par_q [DEPTH];
    logic mem_wpar;

    // Parity of the cleared word is 0, which is what the sequencer stores.
    assign mem_wpar = run ? even_parity(PAR_MAX_W'(mem_wdata)) : 1'b0;

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            par_q[mem_waddr] <= mem_wpar;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Scoreboard: updates only once clearing has finished
    // ------------------------------------------------------------------
    logic [NUM_RD-1:0] sb_busy;

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wr_en_i    (run && wr_en_i),
        .wr_addr_i  (wr_addr_i),
        .rsv_en_i   (run && rsv_en_i),
        .rsv_addr_i (rsv_addr_i),
        .rd_addr_i  (rd_addr_i),
        .busy_o     (sb_busy)
    );

    // ------------------------------------------------------------------
    // Read ports with independent write-through bypass
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_zero;
    logic              rd_hit;

    // While reset is held every output is 0; while clearing the pipeline is stalled.
    always_comb begin
        rd_data_o = '0;
        busy_o    = '0;
        par_err_o = '0;
        rd_addr   = '0;
        rd_zero   = 1'b0;
        rd_hit    = 1'b0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            rd_addr = rd_addr_i[k*ADDR_W +: ADDR_W];
            rd_zero = ZERO_EN && (rd_addr == '0);
            rd_hit  = wr_ok && (wr_addr_i == rd_addr);
            if (!rst_i) begin
                busy_o[k] = 1'b0;
            end else if (!run) begin
                busy_o[k] = 1'b1;
            end else if (rd_hit) begin
                // Bypassed value is the newest one: not busy, no parity check.
                rd_data_o[k*DATA_W +: DATA_W] = wr_data_i;
            end else begin
                if (!rd_zero) begin
                    rd_data_o[k*DATA_W +: DATA_W] = mem_q[rd_addr];
                end
                busy_o[k] = sb_busy[k];
`ifdef REGFILE_PARITY_EN
                par_err_o[k] = !rd_zero && (par_q[rd_addr] ^ (^mem_q[rd_addr]));
`endif
            end
        end
    end

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (default parameters, 2 read ports).
module tb_regfile_mp;

    logic        clk;
    logic        rst_i;
    logic        init_done_o;
    logic [9:0]  rd_addr_i;
    logic [63:0] rd_data_o;
    logic [1:0]  busy_o;
    logic [1:0]  par_err_o;
    logic        wr_en_i;
    logic [4:0]  wr_addr_i;
    logic [31:0] wr_data_i;
    logic        rsv_en_i;
    logic [4:0]  rsv_addr_i;

    int errors = 0;
    int checks = 0;

    regfile_mp dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .init_done_o (init_done_o),
        .rd_addr_i   (rd_addr_i),
        .rd_data_o   (rd_data_o),
        .busy_o      (busy_o),
        .par_err_o   (par_err_o),
        .wr_en_i     (wr_en_i),
        .wr_addr_i   (wr_addr_i),
        .wr_data_i   (wr_data_i),
        .rsv_en_i    (rsv_en_i),
        .rsv_addr_i  (rsv_addr_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge; returns at the following negedge, ready to drive.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Apply all inputs, then let combinational outputs settle.
    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic re, input logic [4:0] ra,
                         input logic [4:0] r0, input logic [4:0] r1);
        wr_en_i    = we;
        wr_addr_i  = wa;
        wr_data_i  = wd;
        rsv_en_i   = re;
        rsv_addr_i = ra;
        rd_addr_i  = {r1, r0};
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b0;
        drive(0, 0, 0, 0, 0, 5, 5);

        // Reset state
        chk("rst_done", 64'(init_done_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_data", rd_data_o, 64'd0);
        chk("rst_par", 64'(par_err_o), 64'd0);

        // 1: clear sequence takes exactly 32 edges, pipeline stalled throughout
        @(negedge clk);
        rst_i = 1'b1;
        #1;
        chk("init_done_0", 64'(init_done_o), 64'd0);
        chk("init_busy_0", 64'(busy_o), 64'd3);
        for (int i = 1; i <= 32; i++) begin
            tick();
            #1;
            chk("init_done", 64'(init_done_o), 64'(i == 32));
            if (i < 32) chk("init_busy", 64'(busy_o), 64'd3);
        end
        for (int a = 0; a < 32; a++) begin
            drive(0, 0, 0, 0, 0, 5'(a), 5'(31 - a));
            chk("init_zero", rd_data_o, 64'd0);
            chk("init_nbusy", 64'(busy_o), 64'd0);
        end

        // 2: write-through bypass on both ports, then stored value
        drive(1, 5, 32'hDEADBEEF, 0, 0, 5, 5);
        chk("byp_both", rd_data_o, 64'hDEADBEEF_DEADBEEF);
        chk("byp_busy", 64'(busy_o), 64'd0);
        tick();
        drive(0, 0, 0, 0, 0, 5, 5);
        chk("stored_r5", rd_data_o, 64'hDEADBEEF_DEADBEEF);

        // 3: r0 ignores writes and reservations
        drive(1, 0, 32'h1234, 1, 0, 0, 0);
        chk("r0_nobyp", rd_data_o, 64'd0);
        chk("r0_busy_now", 64'(busy_o), 64'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("r0_read", rd_data_o, 64'd0);
        chk("r0_busy", 64'(busy_o), 64'd0);

        // 4: reserve r7, busy 3 cycles, write+reserve: bypass clears, set wins after
        drive(0, 0, 0, 1, 7, 7, 5);
        chk("rsv_pre", 64'(busy_o), 64'd0);
        tick();
        drive(0, 0, 0, 0, 0, 7, 5);
        chk("rsv_c1", 64'(busy_o), 64'd1);
        tick();
        #1;
        chk("rsv_c2", 64'(busy_o), 64'd1);
        tick();
        #1;
        chk("rsv_c3", 64'(busy_o), 64'd1);
        tick();
        drive(1, 7, 32'hA5A50007, 1, 7, 7, 5);
        chk("wr_rsv_busy", 64'(busy_o), 64'd0);
        chk("wr_rsv_data", rd_data_o, 64'hDEADBEEF_A5A50007);
        tick();
        drive(0, 0, 0, 0, 0, 7, 5);
        chk("set_wins", 64'(busy_o), 64'd1);
        chk("r7_stored", rd_data_o, 64'hDEADBEEF_A5A50007);
        drive(1, 7, 32'hA5A50007, 0, 0, 9, 5);
        tick();
        drive(0, 0, 0, 0, 0, 7, 5);
        chk("wr_clears", 64'(busy_o), 64'd0);

        // Independent ports: bypass on one port only
        drive(1, 10, 32'h11112222, 0, 0, 0, 0);
        tick();
        drive(1, 11, 32'h33334444, 0, 0, 10, 11);
        chk("byp_p1", rd_data_o, 64'h33334444_11112222);
        tick();
        drive(1, 12, 32'h5555AAAA, 0, 0, 12, 10);
        chk("byp_p0", rd_data_o, 64'h11112222_5555AAAA);
        tick();
        drive(0, 0, 0, 0, 0, 11, 12);
        chk("two_regs", rd_data_o, 64'h5555AAAA_33334444);

        // 6: parity error reporting
        drive(1, 3, 32'h00000007, 0, 0, 3, 5);
        tick();
        drive(0, 0, 0, 0, 0, 3, 5);
        chk("r3_data", rd_data_o, 64'hDEADBEEF_00000007);
        chk("par_clean", 64'(par_err_o), 64'd0);
`ifdef REGFILE_PARITY_EN
        dut.mem_q[3] = dut.mem_q[3] ^ 32'h00000001;
        #1;
        chk("par_flip", 64'(par_err_o), 64'd1);
`endif

        // Reservation pending across reset must be cleared by reset
        drive(0, 0, 0, 1, 9, 3, 9);
        tick();
        drive(0, 0, 0, 0, 0, 3, 9);
        chk("r9_busy", 64'(busy_o), 64'd2);

        // 5: reset, abort init at cnt=10, restart; writes/reservations during init ignored
        rst_i = 1'b0;
        #1;
        chk("rst2_busy", 64'(busy_o), 64'd0);
        chk("rst2_data", rd_data_o, 64'd0);
        chk("rst2_done", 64'(init_done_o), 64'd0);
        tick();
        rst_i = 1'b1;
        for (int i = 1; i <= 10; i++) tick();
        #1;
        chk("mid_done", 64'(init_done_o), 64'd0);
        rst_i = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy_o), 64'd0);
        tick();
        rst_i = 1'b1;
        #1;
        chk("restart_busy", 64'(busy_o), 64'd3);
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (i == 5) begin
                drive(1, 3, 32'h00000BAD, 1, 4, 3, 4);
                chk("init_wr_nobyp", rd_data_o, 64'd0);
                chk("init_wr_busy", 64'(busy_o), 64'd3);
            end else if (i == 6) begin
                drive(0, 0, 0, 0, 0, 3, 4);
            end
            #1;
            if (i >= 31) chk("restart_done", 64'(init_done_o), 64'(i == 32));
        end
        drive(0, 0, 0, 0, 0, 3, 4);
        chk("init_wr_dropped", rd_data_o, 64'd0);
        chk("init_rsv_dropped", 64'(busy_o), 64'd0);
        drive(0, 0, 0, 0, 0, 5, 9);
        chk("r5_cleared", rd_data_o, 64'd0);
        chk("r9_cleared", 64'(busy_o), 64'd0);
        chk("par_after", 64'(par_err_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_regfile_mp
